fp_mul_seq: RTL and testbench
=============================

// Module: fp_mul_seq
// PURPOSE
//  Sequential IEEE-754 single-precision multiplier controller. Accepts operand pairs over valid/ready,
//  classifies both operands (checkspecial, one instance per operand), bypasses NaN/Inf/Zero cases, and
//  otherwise sequences an iterative mantissa multiplier followed by normalise/round.
//  Sits between the operand issue logic and the FP result writeback; one operation in flight at a time.
// PARAMETERS
//  BITS_PER_CYCLE  1   multiplier bits retired per MUL cycle; legal values 1,2,3,4,6,8,12,24
//                      (must divide 24); NMUL = 24/BITS_PER_CYCLE
// PORTS
//  clk        in   1   clock, rising edge
//  rst_n      in   1   asynchronous reset, active low
//  in_valid   in   1   operand pair valid
//  in_ready   out  1   block can accept; high only in IDLE
//  a          in   32  operand A, IEEE-754 single
//  b          in   32  operand B, IEEE-754 single
//  out_valid  out  1   result valid; held until out_ready
//  out_ready  in   1   downstream accepts result
//  result     out  32  product, IEEE-754 single
//  flag_nan   out  1   result is NaN
//  flag_inf   out  1   result is +/-Inf
//  flag_zero  out  1   result is +/-0
//  busy       out  1   high in any state other than IDLE
// BEHAVIOUR
//  Reset: state=IDLE; in_ready=1; out_valid=0; result=0; all flags=0; busy=0. Asserting rst_n low in
//   any state aborts the operation immediately; no result is produced for the aborted operation.
//  Accept: in_valid&&in_ready at a rising edge; a/b are registered at that edge and not sampled again.
//  States: IDLE -> (special) DONE | (normal) MUL -> NORM -> DONE -> IDLE.
//  Special: sa^sb = sign; exp==0 is treated as zero (denormals flushed). Priority order:
//   NaN operand, or Inf x zero -> 32'h7FC00000, flag_nan. Inf operand -> {sign,8'hFF,23'h0}, flag_inf.
//   zero/denormal operand -> {sign,31'h0}, flag_zero. Special results reach DONE 1 edge after accept.
//  MUL: {1,fa} x {1,fb} -> 48-bit P, shift-add over NMUL cycles; exp = ea+eb-127 in 10-bit signed.
//  NORM (1 cycle): if P[47]: mant=P[46:24], g=P[23], s=|P[22:0], exp+1; else mant=P[45:23], g=P[22],
//   s=|P[21:0]. Round-to-nearest-even: up when g&&(s||mant[0]); mantissa carry-out -> mant=0, exp+1.
//   exp>=255 -> {sign,8'hFF,23'h0}, flag_inf. exp<=0 -> {sign,31'h0}, flag_zero (flush).
//  Latency: normal result has out_valid high NMUL+2 edges after accept (26 at default).
//  DONE: out_valid=1; result and flags stable until out_valid&&out_ready. On that edge out_valid=0,
//   state=IDLE, in_ready=1. No new accept occurs on the same edge (in_ready is low in DONE).
//  Flags are mutually exclusive and are 0 for finite non-zero results.
// STRUCTURE
//  fp_pkg: EXP_W=8, MANT_W=23, BIAS=127, QNAN=32'h7FC00000, state enum {IDLE,MUL,NORM,DONE},
//   and the fp32 packed struct {sign,exp,frac}.
//  Sub-module mant_shift_mul: start/done iterative 24x24 multiplier, parameterised by BITS_PER_CYCLE.
//   The controller owns classification, exponent, normalise/round, handshake and the state machine.
// TESTING
//  1) a=3F800000, b=40000000, out_ready=1 -> result=40000000, flags 0, out_valid exactly 26 edges after accept.
//  2) a=7FC00001, b=3F800000 -> result=7FC00000, flag_nan=1, out_valid 1 edge after accept;
//     a=7F800000, b=00000000 -> 7FC00000, flag_nan=1.
//  3) a=7F000000, b=7F000000 -> result=7F800000, flag_inf=1 (overflow); a=00800000, b=00800000 ->
//     result=00000000, flag_zero=1 (underflow flush); a=80000001, b=3F800000 -> 80000000, flag_zero=1.
//  4) a=3F800001, b=3F800001 -> result=3F800002 (round on sticky); a=BFC00000, b=3FC00000 -> C0100000.
//  5) Backpressure: out_ready=0 for 5 cycles after out_valid -> result/flags held, in_ready=0, busy=1;
//     in_valid held high throughout, next pair accepted only after the out_valid&&out_ready edge.
//  6) rst_n low 10 edges into MUL -> out_valid=0, busy=0 immediately; after release in_ready=1 and
//     a fresh operation completes with the correct result; repeat for BITS_PER_CYCLE=4 (latency 8).

Source files
------------

// File: rtl/fp_pkg.sv
// Shared IEEE-754 single-precision types, constants and operand classification
// used by the sequential multiplier.
package fp_pkg;

  localparam int          EXP_W  = 8;
  localparam int          MANT_W = 23;
  localparam int          BIAS   = 127;
  localparam logic [31:0] QNAN   = 32'h7FC00000;

  typedef enum logic [1:0] {IDLE, MUL, NORM, DONE} state_t;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [MANT_W-1:0] frac;
  } fp32_t;

  typedef struct packed {
    logic is_nan;
    logic is_inf;
    logic is_zero;
  } fp_class_t;

  // Denormals (exp == 0) are classified as zero: they are flushed on input.
  function automatic fp_class_t checkspecial(input fp32_t x);
    fp_class_t c;
    c.is_nan  = (x.exp == '1) && (x.frac != '0);
    c.is_inf  = (x.exp == '1) && (x.frac == '0);
    c.is_zero = (x.exp == '0);
    return c;
  endfunction

endpackage

// File: rtl/mant_shift_mul.sv
// Iterative 24x24 unsigned mantissa multiplier retiring BITS_PER_CYCLE multiplier
// bits per cycle by shift-and-add; o_done marks the cycle of the final step.
module mant_shift_mul #(
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_start,
  input  logic [23:0] i_a,
  input  logic [23:0] i_b,
  output logic        o_done,
  output logic [47:0] o_prod
);

  localparam int NMUL  = 24 / BITS_PER_CYCLE;
  localparam int CNT_W = $clog2(NMUL + 1);

  logic [47:0]      r_mcand;
  logic [47:0]      r_acc;
  logic [47:0]      w_acc_nxt;
  logic [23:0]      r_mplier;
  logic [CNT_W-1:0] r_cnt;

  always_comb begin
    w_acc_nxt = r_acc;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      if (r_mplier[i]) w_acc_nxt = w_acc_nxt + (r_mcand << i);
    end
  end

  // r_cnt holds the number of steps still to run; zero means idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              r_cnt <= '0;
    else if (i_start)        r_cnt <= CNT_W'(NMUL);
    else if (r_cnt != '0)    r_cnt <= r_cnt - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (i_start) begin
      r_mcand  <= {24'd0, i_a};
      r_mplier <= i_b;
      r_acc    <= '0;
    end else if (r_cnt != '0) begin
      r_acc    <= w_acc_nxt;
      r_mcand  <= r_mcand << BITS_PER_CYCLE;
      r_mplier <= r_mplier >> BITS_PER_CYCLE;
    end
  end

  // The product in o_prod is complete from the cycle after o_done.
  assign o_done = (r_cnt == CNT_W'(1));
  assign o_prod = r_acc;

endmodule

// File: rtl/fp_mul_seq.sv
// Sequential fp32 multiplier controller: classifies operands, bypasses NaN/Inf/zero,
// otherwise runs the iterative mantissa multiplier then normalises and rounds (RNE).
module fp_mul_seq
  import fp_pkg::*;
#(
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        flag_nan,
  output logic        flag_inf,
  output logic        flag_zero,
  output logic        busy
);

  state_t             r_state, w_state_nxt;
  fp32_t              w_a, w_b;
  fp_class_t          w_ca, w_cb;
  logic               w_accept, w_sign, w_nan, w_inf, w_zero, w_special, w_start;
  logic [31:0]        w_spec_res, w_norm_res, r_result;
  logic               w_mul_done;
  logic [47:0]        w_prod;
  logic               r_sign;
  logic signed [9:0]  r_exp, w_exp_n, w_exp_f;
  logic [22:0]        w_mant;
  logic               w_g, w_s;
  logic [23:0]        w_mant_r;
  logic               w_norm_inf, w_norm_zero;
  logic               r_nan, r_inf, r_zero;

  // Bit 23 of the return value is the mantissa carry-out.
  function automatic logic [23:0] round_rne(input logic [22:0] mant, input logic g,
                                            input logic s);
    return {1'b0, mant} + 24'(g && (s || mant[0]));
  endfunction

  assign w_a  = fp32_t'(a);
  assign w_b  = fp32_t'(b);
  assign w_ca = checkspecial(w_a);
  assign w_cb = checkspecial(w_b);

  assign w_sign    = w_a.sign ^ w_b.sign;
  assign w_nan     = w_ca.is_nan | w_cb.is_nan | (w_ca.is_inf & w_cb.is_zero)
                   | (w_ca.is_zero & w_cb.is_inf);
  assign w_inf     = w_ca.is_inf | w_cb.is_inf;
  assign w_zero    = w_ca.is_zero | w_cb.is_zero;
  assign w_special = w_nan | w_inf | w_zero;
  assign w_accept  = in_valid && in_ready;
  assign w_start   = w_accept && !w_special;

  always_comb begin
    if (w_nan)      w_spec_res = QNAN;
    else if (w_inf) w_spec_res = {w_sign, 8'hFF, 23'h0};
    else            w_spec_res = {w_sign, 31'h0};
  end

  mant_shift_mul #(.BITS_PER_CYCLE(BITS_PER_CYCLE)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_start (w_start),
    .i_a     ({1'b1, w_a.frac}),
    .i_b     ({1'b1, w_b.frac}),
    .o_done  (w_mul_done),
    .o_prod  (w_prod)
  );

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_sign <= w_sign;
      r_exp  <= $signed({2'b00, w_a.exp}) + $signed({2'b00, w_b.exp}) - 10'sd127;
    end
  end

  // Normalise / round: product of two [1,2) mantissas lies in [1,4).
  always_comb begin
    if (w_prod[47]) begin
      w_mant  = w_prod[46:24];
      w_g     = w_prod[23];
      w_s     = |w_prod[22:0];
      w_exp_n = r_exp + 10'sd1;
    end else begin
      w_mant  = w_prod[45:23];
      w_g     = w_prod[22];
      w_s     = |w_prod[21:0];
      w_exp_n = r_exp;
    end
    w_mant_r    = round_rne(w_mant, w_g, w_s);
    w_exp_f     = w_exp_n + $signed({9'd0, w_mant_r[23]});
    w_norm_inf  = (w_exp_f >= 10'sd255);
    w_norm_zero = !w_norm_inf && (w_exp_f <= 10'sd0);
    if (w_norm_inf)       w_norm_res = {r_sign, 8'hFF, 23'h0};
    else if (w_norm_zero) w_norm_res = {r_sign, 31'h0};
    else                  w_norm_res = {r_sign, w_exp_f[7:0], w_mant_r[22:0]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_result <= '0;
      r_nan    <= 1'b0;
      r_inf    <= 1'b0;
      r_zero   <= 1'b0;
    end else if (w_accept && w_special) begin
      r_result <= w_spec_res;
      r_nan    <= w_nan;
      r_inf    <= !w_nan && w_inf;
      r_zero   <= !w_nan && !w_inf && w_zero;
    end else if (r_state == NORM) begin
      r_result <= w_norm_res;
      r_nan    <= 1'b0;
      r_inf    <= w_norm_inf;
      r_zero   <= w_norm_zero;
    end
  end

  assign result    = r_result;
  assign flag_nan  = r_nan;
  assign flag_inf  = r_inf;
  assign flag_zero = r_zero;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_nxt = w_special ? DONE : MUL;
      MUL:     if (w_mul_done) w_state_nxt = NORM;
      NORM:    w_state_nxt = DONE;
      DONE:    if (out_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    busy      = 1'b1;
    out_valid = 1'b0;
    case (r_state)
      IDLE:    begin in_ready = 1'b1; busy = 1'b0; end
      DONE:    out_valid = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_fp_mul_seq.sv
// Bench for fp_mul_seq: directed vectors, handshake/abort sequences and random
// operands against an integer-arithmetic reference, for BITS_PER_CYCLE 1 and 4.
module tb_fp_mul_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, out_ready;
  logic [31:0] a, b;

  logic        ir0, ov0, fn0, fi0, fz0, by0;
  logic        ir1, ov1, fn1, fi1, fz1, by1;
  logic [31:0] res0, res1;

  logic        ir, ov, fn, fi, fz, by;
  logic [31:0] res;
  bit          sel;
  int          nm;
  int          n_chk = 0;
  int          n_pass = 0;

  always #5 clk = ~clk;

  fp_mul_seq #(.BITS_PER_CYCLE(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir0), .a(a), .b(b),
    .out_valid(ov0), .out_ready(out_ready), .result(res0), .flag_nan(fn0),
    .flag_inf(fi0), .flag_zero(fz0), .busy(by0)
  );

  fp_mul_seq #(.BITS_PER_CYCLE(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir1), .a(a), .b(b),
    .out_valid(ov1), .out_ready(out_ready), .result(res1), .flag_nan(fn1),
    .flag_inf(fi1), .flag_zero(fz1), .busy(by1)
  );

  always_comb begin
    ir  = sel ? ir1  : ir0;
    ov  = sel ? ov1  : ov0;
    fn  = sel ? fn1  : fn0;
    fi  = sel ? fi1  : fi0;
    fz  = sel ? fz1  : fz0;
    by  = sel ? by1  : by0;
    res = sel ? res1 : res0;
  end

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    logic [2:0]  f;
    bit          sp;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s (dut%0d): got %h expected %h", name, sel, act, exp);
  endtask

  // Reference: exact integer product, rounded to nearest-even by remainder comparison.
  // Returns {nan, inf, zero, result}.
  function automatic logic [34:0] model(input logic [31:0] x, input logic [31:0] y);
    bit nx, ny, ix, iy, zx, zy, s;
    longint unsigned ma, mb, p, q, rem, half;
    int e, sh;
    nx = (x[30:23] == 8'hFF) && (x[22:0] != 0);
    ny = (y[30:23] == 8'hFF) && (y[22:0] != 0);
    ix = (x[30:23] == 8'hFF) && (x[22:0] == 0);
    iy = (y[30:23] == 8'hFF) && (y[22:0] == 0);
    zx = (x[30:23] == 8'h00);
    zy = (y[30:23] == 8'h00);
    s  = x[31] ^ y[31];
    if (nx || ny || (ix && zy) || (zx && iy)) return {3'b100, 32'h7FC00000};
    if (ix || iy) return {3'b010, s, 8'hFF, 23'h0};
    if (zx || zy) return {3'b001, s, 31'h0};
    ma = 64'(x[22:0]) + (64'd1 << 23);
    mb = 64'(y[22:0]) + (64'd1 << 23);
    p  = ma * mb;
    e  = int'(x[30:23]) + int'(y[30:23]) - 127;
    sh = 23;
    if (p >= (64'd1 << 47)) begin sh = 24; e++; end
    q    = p >> sh;
    rem  = p - (q << sh);
    half = 64'd1 << (sh - 1);
    if (rem > half || (rem == half && q[0])) q++;
    if (q == (64'd1 << 24)) begin q = q >> 1; e++; end
    if (e >= 255) return {3'b010, s, 8'hFF, 23'h0};
    if (e <= 0)   return {3'b001, s, 31'h0};
    return {3'b000, s, 8'(e), q[22:0]};
  endfunction

  function automatic logic [31:0] rand_fp();
    logic [7:0] e;
    int r;
    r = int'($urandom_range(0, 15));
    if (r == 0)      e = 8'h00;
    else if (r == 1) e = 8'hFF;
    else if (r < 8)  e = 8'($urandom_range(100, 154));
    else             e = 8'($urandom_range(1, 254));
    return {1'($urandom), e, 23'($urandom)};
  endfunction

  function automatic bit is_special(input logic [31:0] x, input logic [31:0] y);
    return (x[30:23] == 8'h00) || (x[30:23] == 8'hFF) ||
           (y[30:23] == 8'h00) || (y[30:23] == 8'hFF);
  endfunction

  task automatic wait_ready();
    int t = 0;
    while (ir !== 1'b1 && t < 100) begin @(posedge clk); #1; t++; end
    if (ir !== 1'b1) chk("ready_timeout", 32'(ir), 32'd1);
  endtask

  task automatic wait_valid(output int n);
    n = 1;
    while (ov !== 1'b1 && n < 200) begin @(posedge clk); #1; n++; end
  endtask

  task automatic run_op(input string name, input logic [31:0] xa, input logic [31:0] xb,
                        input logic [31:0] er, input logic [2:0] ef, input int elat);
    int n;
    wait_ready();
    a = xa; b = xb; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_valid(n);
    chk({name, "_lat"}, 32'(n), 32'(elat));
    chk({name, "_res"}, res, er);
    chk({name, "_flags"}, 32'({fn, fi, fz}), 32'(ef));
    @(posedge clk); #1;
  endtask

  task automatic pulse_reset();
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); @(negedge clk); rst_n = 1'b1;
  endtask

  vec_t tbl[9];

  initial begin
    int n;
    logic [31:0] x, y, held;
    logic [34:0] m;

    tbl[0] = '{32'h3F800000, 32'h40000000, 32'h40000000, 3'b000, 1'b0};
    tbl[1] = '{32'h7FC00001, 32'h3F800000, 32'h7FC00000, 3'b100, 1'b1};
    tbl[2] = '{32'h7F800000, 32'h00000000, 32'h7FC00000, 3'b100, 1'b1};
    tbl[3] = '{32'h7F000000, 32'h7F000000, 32'h7F800000, 3'b010, 1'b0};
    tbl[4] = '{32'h00800000, 32'h00800000, 32'h00000000, 3'b001, 1'b0};
    tbl[5] = '{32'h80000001, 32'h3F800000, 32'h80000000, 3'b001, 1'b1};
    tbl[6] = '{32'h3F800001, 32'h3F800001, 32'h3F800002, 3'b000, 1'b0};
    tbl[7] = '{32'hBFC00000, 32'h3FC00000, 32'hC0100000, 3'b000, 1'b0};
    tbl[8] = '{32'hFF800000, 32'h40000000, 32'hFF800000, 3'b010, 1'b1};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; sel = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      chk("rst_in_ready", 32'(ir), 32'd1);
      chk("rst_out_valid", 32'(ov), 32'd0);
      chk("rst_busy", 32'(by), 32'd0);
      chk("rst_result", res, 32'h0);
      chk("rst_flags", 32'({fn, fi, fz}), 32'd0);
    end

    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      nm  = sel ? 6 : 24;
      pulse_reset();
      #1;

      for (int i = 0; i < 9; i++)
        run_op($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].r, tbl[i].f,
               tbl[i].sp ? 1 : nm + 2);

      // Backpressure: result held while out_ready is low; next pair waits for handshake.
      wait_ready();
      a = 32'h3FC00000; b = 32'h3FC00000; in_valid = 1'b1; out_ready = 1'b0;
      @(posedge clk); #1;
      a = 32'h40400000; b = 32'h40000000;
      wait_valid(n);
      chk("bp_lat", 32'(n), 32'(nm + 2));
      chk("bp_res", res, 32'h40100000);
      held = res;
      for (int k = 0; k < 5; k++) begin
        @(posedge clk); #1;
        chk("bp_hold_res", res, held);
        chk("bp_hold_flags", 32'({fn, fi, fz}), 32'd0);
        chk("bp_hold_ready", 32'(ir), 32'd0);
        chk("bp_hold_busy", 32'(by), 32'd1);
        chk("bp_hold_valid", 32'(ov), 32'd1);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      chk("bp_release_valid", 32'(ov), 32'd0);
      chk("bp_release_ready", 32'(ir), 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("bp_second_accept", 32'(by), 32'd1);
      wait_valid(n);
      chk("bp_second_lat", 32'(n), 32'(nm + 2));
      chk("bp_second_res", res, 32'h40C00000);
      @(posedge clk); #1;

      // Abort mid-MUL with an asynchronous reset.
      wait_ready();
      a = 32'h3F800000; b = 32'h40400000; in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (sel ? 4 : 10) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("abort_valid", 32'(ov), 32'd0);
      chk("abort_busy", 32'(by), 32'd0);
      @(negedge clk); rst_n = 1'b1;
      #1;
      chk("abort_ready", 32'(ir), 32'd1);
      run_op("after_abort", 32'h3F800000, 32'h40400000, 32'h40400000, 3'b000, nm + 2);

      for (int i = 0; i < 20; i++) begin
        x = rand_fp();
        y = rand_fp();
        m = model(x, y);
        run_op($sformatf("rnd%0d_%h_%h", i, x, y), x, y, m[31:0], m[34:32],
               is_special(x, y) ? 1 : nm + 2);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
